vram_sketch_writer: RTL and testbench

//  Generalised etch-a-sketch VRAM writer. Owns the VRAM write port and

---
 rtl/vram_sketch_writer_pkg.sv | 39 +++
 rtl/vram_sketch_writer_brush_raster.sv | 82 ++++++++
 rtl/vram_sketch_writer.sv | 233 +++++++++++++++++++++++
 tb/tb_vram_sketch_writer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_sketch_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_sketch_writer_pkg
// Description : Shared types for the sketch VRAM writer: touch sample,
//               panel colour, writer FSM states and the pixel address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_sketch_writer_pkg;

    localparam int TOUCH_COORD_W   = 16;
    localparam int ILI9341_COLOR_W = 16;

    typedef logic [ILI9341_COLOR_W-1:0] ILI9341_color_t;

    localparam ILI9341_color_t BLACK = 16'h0000;

    // One touch-controller sample: coordinates are raw and may be off-panel.
    typedef struct packed {
        logic                     valid;
        logic [TOUCH_COORD_W-1:0] x;
        logic [TOUCH_COORD_W-1:0] y;
    } touch_t;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_BRUSH = 2'd2
    } state_t;

    // Row-major pixel address, evaluated at 32 bits so the multiply never
    // truncates before the caller narrows to its address width.
    function automatic logic [31:0] xy_to_addr(input logic [31:0] x,
                                               input logic [31:0] y,
                                               input logic [31:0] width);
        return (y * width) + x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_sketch_writer_brush_raster.sv
`default_nettype none
// ============================================================================
// Module      : vram_sketch_writer_brush_raster
// Description : Square brush scanner. Loaded with a centre and radius, it
//               walks dy=-r..+r (outer) and dx=-r..+r (inner), one position
//               per step, flagging positions that fall off the display.
// Ports       : i_load/i_cx/i_cy/i_radius - start a new brush
//               i_step                    - advance to the next position
//               o_x/o_y                   - current pixel (valid when !o_clip)
//               o_clip                    - current position is off-display
//               o_done                    - current position is the last one
// Revision    : 1.0 - initial release
// ============================================================================
module vram_sketch_writer_brush_raster #(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int X_W            = 8,
    parameter int Y_W            = 9,
    parameter int RAD_W          = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [X_W-1:0]   i_cx,
    input  logic [Y_W-1:0]   i_cy,
    input  logic [RAD_W-1:0] i_radius,
    output logic [X_W-1:0]   o_x,
    output logic [Y_W-1:0]   o_y,
    output logic             o_clip,
    output logic             o_done
);

    localparam logic signed [X_W+1:0] c_W_S = (X_W+2)'(DISPLAY_WIDTH);
    localparam logic signed [Y_W+1:0] c_H_S = (Y_W+2)'(DISPLAY_HEIGHT);

    logic signed [X_W+1:0] r_cx, r_dx;
    logic signed [Y_W+1:0] r_cy, r_dy;
    logic [RAD_W-1:0]      r_rad;

    logic signed [X_W+1:0] w_rad_x, w_ld_rad_x, w_px;
    logic signed [Y_W+1:0] w_rad_y, w_ld_rad_y, w_py;

    assign w_rad_x    = $signed((X_W+2)'(r_rad));
    assign w_rad_y    = $signed((Y_W+2)'(r_rad));
    assign w_ld_rad_x = $signed((X_W+2)'(i_radius));
    assign w_ld_rad_y = $signed((Y_W+2)'(i_radius));

    assign w_px = r_cx + r_dx;
    assign w_py = r_cy + r_dy;

    // Sign bit catches the left/top edge, the compare the right/bottom edge.
    assign o_clip = w_px[X_W+1] || (w_px >= c_W_S) || w_py[Y_W+1] || (w_py >= c_H_S);
    assign o_done = (r_dx == w_rad_x) && (r_dy == w_rad_y);
    assign o_x    = w_px[X_W-1:0];
    assign o_y    = w_py[Y_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cx  <= '0;
            r_cy  <= '0;
            r_dx  <= '0;
            r_dy  <= '0;
            r_rad <= '0;
        end else if (i_load) begin
            r_cx  <= $signed((X_W+2)'(i_cx));
            r_cy  <= $signed((Y_W+2)'(i_cy));
            r_dx  <= -w_ld_rad_x;
            r_dy  <= -w_ld_rad_y;
            r_rad <= i_radius;
        end else if (i_step) begin
            if (r_dx == w_rad_x) begin
                r_dx <= -w_rad_x;
                r_dy <= r_dy + (Y_W+2)'(1);
            end else begin
                r_dx <= r_dx + (X_W+2)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vram_sketch_writer.sv
`default_nettype none
// ============================================================================
// Module      : vram_sketch_writer
// Description : Etch-a-sketch VRAM writer. Clears the frame buffer after
//               reset or on request, then arbitrates N_TOUCH touch channels
//               round-robin and paints a clipped square brush per touch.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_ena               - 0 freezes the FSM and gates writes
//               i_clear_req         - restart a full clear
//               i_brush_radius      - brush radius, saturated to MAX_RADIUS
//               i_touch / i_color   - per-channel touch sample and colour
//               o_vram_wr_*         - registered VRAM write port
//               o_busy              - clearing or painting
//               o_clear_done        - pulse after the last clear write
// Revision    : 1.0 - initial release
// ============================================================================
module vram_sketch_writer
    import vram_sketch_writer_pkg::*;
#(
    parameter int                  DISPLAY_WIDTH  = 240,
    parameter int                  DISPLAY_HEIGHT = 320,
    parameter int                  VRAM_W         = 16,
    parameter int                  N_TOUCH        = 2,
    parameter int                  MAX_RADIUS     = 3,
    parameter logic [VRAM_W-1:0]   CLEAR_COLOR    = VRAM_W'(BLACK)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_ena,
    input  logic                               i_clear_req,
    input  logic [$clog2(MAX_RADIUS+1)-1:0]    i_brush_radius,
    input  touch_t [N_TOUCH-1:0]               i_touch,
    input  logic [VRAM_W*N_TOUCH-1:0]          i_color,
    output logic                               o_vram_wr_ena,
    output logic [$clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)-1:0] o_vram_wr_addr,
    output logic [VRAM_W-1:0]                  o_vram_wr_data,
    output logic                               o_busy,
    output logic                               o_clear_done
);

    localparam int VRAM_L = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam int ADDR_W = $clog2(VRAM_L);
    localparam int X_W    = $clog2(DISPLAY_WIDTH);
    localparam int Y_W    = $clog2(DISPLAY_HEIGHT);
    localparam int RAD_W  = $clog2(MAX_RADIUS+1);
    localparam int PTR_W  = (N_TOUCH > 1) ? $clog2(N_TOUCH) : 1;

    localparam logic [TOUCH_COORD_W-1:0] c_W_T = TOUCH_COORD_W'(DISPLAY_WIDTH);
    localparam logic [TOUCH_COORD_W-1:0] c_H_T = TOUCH_COORD_W'(DISPLAY_HEIGHT);

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_TOUCH-1)) ? '0 : p + 1'b1;
    endfunction

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic                r_clr_pend;
    logic [PTR_W-1:0]    r_rr, r_win;
    logic [VRAM_W-1:0]   r_col;
    logic                r_wr_ena, r_busy, r_clear_done;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [VRAM_W-1:0]   r_wr_data;
    logic [N_TOUCH-1:0]  r_last_vld;
    logic [X_W-1:0]      r_last_x   [N_TOUCH];
    logic [Y_W-1:0]      r_last_y   [N_TOUCH];
    logic [VRAM_W-1:0]   r_last_col [N_TOUCH];

    logic [N_TOUCH-1:0]  w_ok;
    logic [VRAM_W-1:0]   w_col [N_TOUCH];
    logic                w_hit, w_dup, w_run, w_load, w_step;
    logic [PTR_W-1:0]    w_win;
    touch_t              w_wt;
    logic [X_W-1:0]      w_tx, w_bx;
    logic [Y_W-1:0]      w_ty, w_by;
    logic [VRAM_W-1:0]   w_tcol;
    logic [RAD_W-1:0]    w_rad_sat;
    logic                w_clip, w_done;
    logic [ADDR_W-1:0]   w_brush_addr;

    for (genvar g = 0; g < N_TOUCH; g++) begin : g_chan
        assign w_ok[g]  = i_touch[g].valid && (i_touch[g].x < c_W_T) && (i_touch[g].y < c_H_T);
        assign w_col[g] = i_color[g*VRAM_W +: VRAM_W];
    end

    // Round-robin: first pass takes channels at or after the pointer, the
    // second pass wraps around to the ones before it.
    always_comb begin
        w_hit = 1'b0;
        w_win = r_rr;
        for (int k = 0; k < N_TOUCH; k++) begin
            if (!w_hit && w_ok[k] && (PTR_W'(k) >= r_rr)) begin
                w_hit = 1'b1;
                w_win = PTR_W'(k);
            end
        end
        for (int k = 0; k < N_TOUCH; k++) begin
            if (!w_hit && w_ok[k]) begin
                w_hit = 1'b1;
                w_win = PTR_W'(k);
            end
        end
    end

    assign w_wt      = i_touch[w_win];
    assign w_tx      = w_wt.x[X_W-1:0];
    assign w_ty      = w_wt.y[Y_W-1:0];
    assign w_tcol    = w_col[w_win];
    assign w_dup     = r_last_vld[w_win] && (r_last_x[w_win] == w_tx) &&
                       (r_last_y[w_win] == w_ty) && (r_last_col[w_win] == w_tcol);
    assign w_rad_sat = ({1'b0, i_brush_radius} > (RAD_W+1)'(MAX_RADIUS)) ?
                       RAD_W'(MAX_RADIUS) : i_brush_radius;

    assign w_run  = i_ena && !i_clear_req;
    assign w_load = w_run && (r_state == S_IDLE) && w_hit && !w_dup;
    assign w_step = w_run && (r_state == S_BRUSH);

    vram_sketch_writer_brush_raster #(
        .DISPLAY_WIDTH  (DISPLAY_WIDTH),
        .DISPLAY_HEIGHT (DISPLAY_HEIGHT),
        .X_W            (X_W),
        .Y_W            (Y_W),
        .RAD_W          (RAD_W)
    ) u_raster (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_cx     (w_tx),
        .i_cy     (w_ty),
        .i_radius (w_rad_sat),
        .o_x      (w_bx),
        .o_y      (w_by),
        .o_clip   (w_clip),
        .o_done   (w_done)
    );

    assign w_brush_addr = ADDR_W'(xy_to_addr(32'(w_bx), 32'(w_by), 32'(DISPLAY_WIDTH)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_CLEAR;
            r_clr_cnt    <= ADDR_W'(VRAM_L-1);
            r_clr_pend   <= 1'b0;
            r_rr         <= '0;
            r_win        <= '0;
            r_col        <= '0;
            r_wr_ena     <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b1;
            r_clear_done <= 1'b0;
            r_last_vld   <= '0;
            for (int k = 0; k < N_TOUCH; k++) begin
                r_last_x[k]   <= '0;
                r_last_y[k]   <= '0;
                r_last_col[k] <= '0;
            end
        end else if (!i_ena) begin
            r_wr_ena <= 1'b0;
        end else if (i_clear_req) begin
            // Clear pre-empts everything, including a touch seen this cycle.
            r_state      <= S_CLEAR;
            r_clr_cnt    <= ADDR_W'(VRAM_L-1);
            r_clr_pend   <= 1'b0;
            r_wr_ena     <= 1'b0;
            r_busy       <= 1'b1;
            r_clear_done <= 1'b0;
            r_last_vld   <= '0;
        end else begin
            r_wr_ena     <= 1'b0;
            r_clear_done <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_wr_ena  <= 1'b1;
                    r_wr_addr <= r_clr_cnt;
                    r_wr_data <= CLEAR_COLOR;
                    if (r_clr_cnt == '0) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_clr_pend <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (r_clr_pend) begin
                        r_clear_done <= 1'b1;
                        r_clr_pend   <= 1'b0;
                    end
                    if (w_hit) begin
                        if (w_dup) begin
                            r_rr <= f_next(w_win);
                        end else begin
                            r_win             <= w_win;
                            r_col             <= w_tcol;
                            r_last_vld[w_win] <= 1'b1;
                            r_last_x[w_win]   <= w_tx;
                            r_last_y[w_win]   <= w_ty;
                            r_last_col[w_win] <= w_tcol;
                            r_state           <= S_BRUSH;
                            r_busy            <= 1'b1;
                        end
                    end
                end
                S_BRUSH: begin
                    if (!w_clip) begin
                        r_wr_ena  <= 1'b1;
                        r_wr_addr <= w_brush_addr;
                        r_wr_data <= r_col;
                    end
                    if (w_done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_rr    <= f_next(r_win);
                    end
                end
                default: begin
                    r_state   <= S_CLEAR;
                    r_clr_cnt <= ADDR_W'(VRAM_L-1);
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign o_vram_wr_ena  = r_wr_ena;
    assign o_vram_wr_addr = r_wr_addr;
    assign o_vram_wr_data = r_wr_data;
    assign o_busy         = r_busy;
    assign o_clear_done   = r_clear_done;

endmodule
`default_nettype wire

// File: tb/tb_vram_sketch_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_sketch_writer
// Description : Scoreboard bench for vram_sketch_writer on a 4x3 panel with
//               two touch channels and radius up to 1. Expected writes carry
//               the address, data and the clock edge they must appear on.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_sketch_writer;
    import vram_sketch_writer_pkg::*;

    localparam int          TB_AW = 4;
    localparam logic [15:0] CLR   = 16'h0841;

    typedef struct {
        logic [TB_AW-1:0] addr;
        logic [15:0]      data;
        int               stamp;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             clear_req;
    logic [0:0]       radius;
    touch_t [1:0]     touch;
    logic [31:0]      color;
    logic             wr_ena;
    logic [TB_AW-1:0] wr_addr;
    logic [15:0]      wr_data;
    logic             busy;
    logic             clear_done;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  pcyc     = 0;
    int  done_cnt = 0;
    int  n_cmp    = 0;
    int  n_bad    = 0;

    vram_sketch_writer #(
        .DISPLAY_WIDTH  (4),
        .DISPLAY_HEIGHT (3),
        .VRAM_W         (16),
        .N_TOUCH        (2),
        .MAX_RADIUS     (1),
        .CLEAR_COLOR    (CLR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_ena          (ena),
        .i_clear_req    (clear_req),
        .i_brush_radius (radius),
        .i_touch        (touch),
        .i_color        (color),
        .o_vram_wr_ena  (wr_ena),
        .o_vram_wr_addr (wr_addr),
        .o_vram_wr_data (wr_data),
        .o_busy         (busy),
        .o_clear_done   (clear_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcyc <= pcyc + 1;

    // Recorder only: every observed write is stamped with the edge count.
    always @(negedge clk) begin
        if (wr_ena === 1'b1) obs_q.push_back('{wr_addr, wr_data, pcyc});
        if (clear_done === 1'b1) done_cnt++;
    end

    task automatic test_reset;
        int  p0;
        wr_t e, o;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: actual %b required 1", busy); end
        n_cmp++; if (wr_ena !== 1'b0) begin n_bad++; $display("FAIL rst_wr_ena: actual %b required 0", wr_ena); end
        n_cmp++; if (wr_addr !== '0) begin n_bad++; $display("FAIL rst_addr: actual %0d required 0", wr_addr); end
        n_cmp++; if (wr_data !== '0) begin n_bad++; $display("FAIL rst_data: actual %h required 0000", wr_data); end
        n_cmp++; if (clear_done !== 1'b0) begin n_bad++; $display("FAIL rst_clear_done: actual %b required 0", clear_done); end
        rst = 1'b0;
        obs_q.delete(); done_cnt = 0; p0 = pcyc;
        for (int k = 0; k < 12; k++) exp_q.push_back('{TB_AW'(11-k), CLR, p0+1+k});
        repeat (20) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL reset_clear: missing write, required addr %0d data %h", e.addr, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data || o.stamp != e.stamp) begin
                    n_bad++;
                    $display("FAIL reset_clear: actual addr %0d data %h cyc %0d, required addr %0d data %h cyc %0d",
                             o.addr, o.data, o.stamp, e.addr, e.data, e.stamp);
                end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL reset_clear_extra: actual %0d extra writes required 0", obs_q.size()); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL reset_clear_done: actual %0d pulses required 1", done_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_end: actual %b required 0", busy); end
    endtask

    task automatic test_single_pixel;
        int  p0;
        wr_t e, o;
        obs_q.delete();
        radius   = 1'b0;
        color    = {16'h0000, 16'hF81F};
        touch[0] = '{1'b1, 16'd2, 16'd1};
        p0 = pcyc;
        exp_q.push_back('{TB_AW'(6), 16'hF81F, p0+2});
        repeat (12) @(negedge clk);
        touch[0].valid = 1'b0;
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL single_pixel: missing write, required addr %0d data %h", e.addr, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data || o.stamp != e.stamp) begin
                    n_bad++;
                    $display("FAIL single_pixel: actual addr %0d data %h cyc %0d, required addr %0d data %h cyc %0d",
                             o.addr, o.data, o.stamp, e.addr, e.data, e.stamp);
                end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL single_pixel_dup: actual %0d extra writes required 0", obs_q.size()); end
    endtask

    task automatic test_brush_clip;
        int  p0;
        int  busy_cnt;
        wr_t e, o;
        obs_q.delete();
        busy_cnt = 0;
        radius   = 1'b1;
        color    = {16'hFFFF, 16'h07E0};
        touch[0] = '{1'b1, 16'd0, 16'd0};
        touch[1] = '{1'b1, 16'd4, 16'd0};   // just off the right edge: ignored
        p0 = pcyc;
        exp_q.push_back('{TB_AW'(0), 16'h07E0, p0+6});
        exp_q.push_back('{TB_AW'(1), 16'h07E0, p0+7});
        exp_q.push_back('{TB_AW'(4), 16'h07E0, p0+9});
        exp_q.push_back('{TB_AW'(5), 16'h07E0, p0+10});
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
        end
        touch[0].valid = 1'b0;
        touch[1].valid = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL brush_clip: missing write, required addr %0d data %h", e.addr, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data || o.stamp != e.stamp) begin
                    n_bad++;
                    $display("FAIL brush_clip: actual addr %0d data %h cyc %0d, required addr %0d data %h cyc %0d",
                             o.addr, o.data, o.stamp, e.addr, e.data, e.stamp);
                end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL brush_clip_extra: actual %0d extra writes required 0", obs_q.size()); end
        n_cmp++; if (busy_cnt != 9) begin n_bad++; $display("FAIL brush_busy_cycles: actual %0d required 9", busy_cnt); end
    endtask

    task automatic test_back_to_back;
        int  p0;
        wr_t e, o;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (16) @(negedge clk);
        obs_q.delete();
        radius = 1'b0;
        color  = {16'h5555, 16'hAAAA};
        p0 = pcyc;
        for (int i = 0; i < 4; i++) begin
            touch[0] = '{1'b1, 16'(i), 16'd0};
            touch[1] = '{1'b1, 16'(3-i), 16'd2};
            if (i % 2 == 0) exp_q.push_back('{TB_AW'(i), 16'hAAAA, p0+2+2*i});
            else            exp_q.push_back('{TB_AW'(11-i), 16'h5555, p0+2+2*i});
            repeat (2) @(negedge clk);
        end
        touch[0].valid = 1'b0;
        touch[1].valid = 1'b0;
        repeat (6) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL back_to_back: missing write, required addr %0d data %h", e.addr, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data || o.stamp != e.stamp) begin
                    n_bad++;
                    $display("FAIL back_to_back: actual addr %0d data %h cyc %0d, required addr %0d data %h cyc %0d",
                             o.addr, o.data, o.stamp, e.addr, e.data, e.stamp);
                end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL back_to_back_extra: actual %0d extra writes required 0", obs_q.size()); end
    endtask

    task automatic test_clear_abort;
        int  p0;
        wr_t e, o;
        obs_q.delete(); done_cnt = 0;
        radius   = 1'b1;
        color    = {16'h0000, 16'h001F};
        touch[0] = '{1'b1, 16'd1, 16'd1};
        p0 = pcyc;
        exp_q.push_back('{TB_AW'(0), 16'h001F, p0+2});
        exp_q.push_back('{TB_AW'(1), 16'h001F, p0+3});
        for (int k = 0; k < 12; k++) exp_q.push_back('{TB_AW'(11-k), CLR, p0+5+k});
        repeat (3) @(negedge clk);
        clear_req      = 1'b1;              // seen on brush cycle 3
        touch[0].valid = 1'b0;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (20) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL clear_abort: missing write, required addr %0d data %h", e.addr, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data || o.stamp != e.stamp) begin
                    n_bad++;
                    $display("FAIL clear_abort: actual addr %0d data %h cyc %0d, required addr %0d data %h cyc %0d",
                             o.addr, o.data, o.stamp, e.addr, e.data, e.stamp);
                end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL clear_abort_extra: actual %0d extra writes required 0", obs_q.size()); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL clear_abort_done: actual %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_ena_freeze;
        int  p0;
        wr_t e, o;
        obs_q.delete(); done_cnt = 0;
        p0 = pcyc;
        clear_req = 1'b1;
        for (int k = 0; k < 3; k++)  exp_q.push_back('{TB_AW'(11-k), CLR, p0+2+k});
        for (int k = 0; k < 9; k++)  exp_q.push_back('{TB_AW'(8-k), CLR, p0+10+k});
        @(negedge clk);
        clear_req = 1'b0;
        repeat (3) @(negedge clk);
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) begin
                n_cmp++; if (wr_addr !== TB_AW'(9)) begin n_bad++; $display("FAIL freeze_addr_hold: actual %0d required 9", wr_addr); end
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL freeze_busy: actual %b required 1", busy); end
            end
        end
        ena = 1'b1;
        repeat (16) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL ena_freeze: missing write, required addr %0d data %h", e.addr, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data || o.stamp != e.stamp) begin
                    n_bad++;
                    $display("FAIL ena_freeze: actual addr %0d data %h cyc %0d, required addr %0d data %h cyc %0d",
                             o.addr, o.data, o.stamp, e.addr, e.data, e.stamp);
                end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL ena_freeze_extra: actual %0d extra writes required 0", obs_q.size()); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL ena_freeze_done: actual %0d pulses required 1", done_cnt); end
    endtask

    initial begin
        rst       = 1'b1;
        ena       = 1'b1;
        clear_req = 1'b0;
        radius    = 1'b0;
        touch     = '0;
        color     = '0;
        test_reset();
        test_single_pixel();
        test_brush_clip();
        test_back_to_back();
        test_clear_abort();
        test_ena_freeze();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
